ysyx_lsu: RTL
=============

Name: ysyx_lsu

Overview:
- Load/store unit directly downstream of the execute stage.
- Accepts one memory request at a time: address, func3 size/sign code, store data.
- Runs it on an AXI4-Lite-style data bus master port.
- Returns aligned, extended load data (one-cycle `exu_rvalid` pulse) or a store-done pulse (`exu_wready`), matching the execute stage's hold-until-pulse request protocol.

Parameters:
- BIT_W, 32, data/address width.
- RESP_OK, 2'b00, the only bus response treated as success.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- exu_ren  in  1  request is a load (valid while exu_avalid)
- exu_wen  in  1  request is a store
- exu_avalid  in  1  request valid; held high until the matching done pulse
- exu_addr  in  BIT_W  byte address
- exu_op  in  4  [2:0] = RV32 load/store func3; [3] ignored
- exu_wdata  in  BIT_W  store data, unaligned (LSB-justified)
- exu_rdata  out  BIT_W  formatted load result, valid with exu_rvalid
- exu_rvalid  out  1  one-cycle load-done pulse
- exu_wready  out  1  one-cycle store-done pulse
- exu_err  out  1  pulses with the done pulse on misalignment or bus error
- araddr/arvalid/arready  out/out/in  BIT_W/1/1  read address channel
- rdata/rresp/rvalid/rready  in/in/in/out  BIT_W/2/1/1  read data channel
- awaddr/awvalid/awready  out/out/in  BIT_W/1/1  write address channel
- wdata/wstrb/wvalid/wready  out/out/out/in  BIT_W/4/1/1  write data channel
- bresp/bvalid/bready  in/in/out  2/1/1  write response channel

Behaviour:
- Reset (rst=0, async): state IDLE; all valid/ready/pulse outputs 0; exu_rdata, araddr, awaddr, wdata, wstrb = 0.
- Reset mid-transaction abandons the transaction with no pulse; the bench keeps the slave idle across reset.
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
- IDLE, exu_avalid=1: latch addr, op, wdata, ren/wen. ren and wen both 1 is illegal; ren wins.
- Misaligned access goes straight to DONE with err=1 and issues no bus traffic: H with addr[0]=1; W with addr[1:0]≠0.
- Load path:
  - RD_A: arvalid=1, araddr = latched address unmodified. On arready, go to RD_D.
  - RD_D: rready=1. On rvalid, register the formatted data, record err = (rresp≠RESP_OK), go to DONE.
- Load format:
  - Shift rdata right by addr[1:0]*8.
  - Byte: func3 000 sign-extends bit 7; 100 zero-extends.
  - Half: 001 sign-extends bit 15; 101 zero-extends.
  - 010 passes the word through.
- Store path:
  - WR_AW: awvalid and wvalid both asserted. Each drops independently on its own handshake (per-channel done flags). When both are done, go to WR_B.
  - WR_B: bready=1. On bvalid, err = (bresp≠RESP_OK), go to DONE.
- Store format:
  - wdata = store data shifted left by addr[1:0]*8.
  - wstrb: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111.
- DONE lasts exactly one cycle:
  - Pulse exu_rvalid (load) or exu_wready (store); exu_err = err.
  - Next state is IDLE unconditionally.
  - exu_avalid is still high during DONE (the requester clears it on this edge) and is not resampled.
  - IDLE re-accepts only from the following cycle.
- exu_rdata holds its value until the next load completes.
- Latency with a zero-wait slave, request seen in IDLE at cycle 0:
  - Bus valid at cycle 1.
  - Data/response accepted at cycle 2.
  - Pulse at cycle 3.
- Each wait cycle on any channel adds one cycle.
- A response arriving in the same cycle as its address handshake is not accepted until the next state.
- Back-to-back: a new request may be accepted in the cycle after DONE, giving 4 cycles per zero-wait access.
- Unused bus handshake inputs arriving outside their states are ignored.

Decomposition:
- Package ysyx_lsu_pkg:
  - state enum;
  - func3 constants LSU_F3_B/H/W/BU/HU;
  - RESP_OK.
- Sub-module ysyx_lsu_fmt (combinational): load extract/extend and store shift/strobe generation. The FSM and channel handshakes stay in ysyx_lsu.

Test Plan:
- LW addr 0x80000004, zero-wait slave returns 0xDEADBEEF: arvalid at cycle 1, araddr=0x80000004; exu_rvalid pulses at cycle 3 with exu_rdata=0xDEADBEEF, err=0.
- LB addr 0x80000003, rdata=0x80112233: exu_rdata=0xFFFFFF80. LBU same address: 0x00000080. LHU addr 0x80000002: 0x00008011.
- SH addr 0x80000002, data 0x0000ABCD, awready delayed 2 cycles and wready immediate: wvalid drops after 1 cycle and awvalid after 3; wdata=0xABCD0000, wstrb=0011<<2=1100; exu_wready pulses one cycle after bvalid.
- LW addr 0x80000001: no arvalid ever; pulse at cycle 1 with exu_err=1. SW with bresp=2'b10: exu_wready and exu_err pulse together.
- Back-to-back SB then LW with avalid held until each pulse: exactly one bus transaction per request; second accepted the cycle after the first DONE.
- rst asserted low while in RD_D: arvalid/rready/pulses drop immediately (asynchronously); after release, the state is IDLE and a new LW completes normally.

Source files
------------

// File: rtl/ysyx_lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_e    : FSM state encoding for ysyx_lsu
//   LSU_F3_*       : RV32 load/store func3 codes
//   RESP_OK        : the only bus response treated as success
//   lsu_misaligned : misalignment check for a size code and byte offset
package ysyx_lsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdD,
    StWrAw,
    StWrB,
    StDone
  } lsu_state_e;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  localparam logic [1:0] RESP_OK = 2'b00;

  // size is func3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_lsu_fmt.sv
// Combinational data formatting for the load/store unit.
//   ld_op, ld_addr_lo, rdata   : load func3, byte offset and raw bus word
//   ld_data                    : right-justified, sign/zero-extended load result
//   st_size, st_addr_lo, st_data : store size (func3[1:0]), byte offset, LSB-justified data
//   st_wdata, st_wstrb         : lane-aligned store data and byte strobes
module ysyx_lsu_fmt
  import ysyx_lsu_pkg::*;
#(
  parameter int unsigned BIT_W = 32
) (
  input  logic [2:0]         ld_op,
  input  logic [1:0]         ld_addr_lo,
  input  logic [BIT_W-1:0]   rdata,
  output logic [BIT_W-1:0]   ld_data,
  input  logic [1:0]         st_size,
  input  logic [1:0]         st_addr_lo,
  input  logic [BIT_W-1:0]   st_data,
  output logic [BIT_W-1:0]   st_wdata,
  output logic [BIT_W/8-1:0] st_wstrb
);

  localparam int unsigned StrbW = BIT_W / 8;

  logic [BIT_W-1:0] ld_shifted;

  always_comb begin
    ld_shifted = rdata >> {ld_addr_lo, 3'b000};
    case (ld_op)
      LSU_F3_B:  ld_data = {{(BIT_W-8){ld_shifted[7]}}, ld_shifted[7:0]};
      LSU_F3_BU: ld_data = {{(BIT_W-8){1'b0}}, ld_shifted[7:0]};
      LSU_F3_H:  ld_data = {{(BIT_W-16){ld_shifted[15]}}, ld_shifted[15:0]};
      LSU_F3_HU: ld_data = {{(BIT_W-16){1'b0}}, ld_shifted[15:0]};
      LSU_F3_W:  ld_data = ld_shifted;
      default:   ld_data = ld_shifted;
    endcase
  end

  always_comb begin
    st_wdata = st_data << {st_addr_lo, 3'b000};
    case (st_size)
      2'b00:   st_wstrb = StrbW'(1) << st_addr_lo;
      2'b01:   st_wstrb = StrbW'(3) << st_addr_lo;
      default: st_wstrb = '1;
    endcase
  end

endmodule

// File: rtl/ysyx_lsu.sv
// Load/store unit sitting after the execute stage. Takes one request at a time
// (held valid until its done pulse), runs it on an AXI4-Lite-style master port
// and returns either a formatted load result or a store-done pulse.
//   clk, rst                      : clock, asynchronous active-low reset
//   exu_ren/wen/avalid/addr/op/wdata : request from execute (ren wins over wen)
//   exu_rdata, exu_rvalid         : load result and one-cycle load-done pulse
//   exu_wready                    : one-cycle store-done pulse
//   exu_err                       : error flag, valid with either done pulse
//   ar*/r*/aw*/w*/b*              : data bus master channels
module ysyx_lsu
  import ysyx_lsu_pkg::*;
#(
  parameter int unsigned BIT_W   = 32,
  parameter logic [1:0]  RESP_OK = ysyx_lsu_pkg::RESP_OK
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exu_ren,
  input  logic               exu_wen,
  input  logic               exu_avalid,
  input  logic [BIT_W-1:0]   exu_addr,
  input  logic [3:0]         exu_op,
  input  logic [BIT_W-1:0]   exu_wdata,
  output logic [BIT_W-1:0]   exu_rdata,
  output logic               exu_rvalid,
  output logic               exu_wready,
  output logic               exu_err,
  output logic [BIT_W-1:0]   araddr,
  output logic               arvalid,
  input  logic               arready,
  input  logic [BIT_W-1:0]   rdata,
  input  logic [1:0]         rresp,
  input  logic               rvalid,
  output logic               rready,
  output logic [BIT_W-1:0]   awaddr,
  output logic               awvalid,
  input  logic               awready,
  output logic [BIT_W-1:0]   wdata,
  output logic [BIT_W/8-1:0] wstrb,
  output logic               wvalid,
  input  logic               wready,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready
);

  localparam int unsigned StrbW = BIT_W / 8;

  lsu_state_e       state_q;
  logic [1:0]       addr_lo_q;
  logic [2:0]       op_q;

  logic [BIT_W-1:0] ld_data;
  logic [BIT_W-1:0] st_wdata;
  logic [StrbW-1:0] st_wstrb;
  logic             req_misaligned;
  logic             aw_done;
  logic             w_done;
  logic             unused_op;

  assign unused_op      = exu_op[3];
  assign req_misaligned = lsu_misaligned(exu_op[1:0], exu_addr[1:0]);

  // awvalid/wvalid double as per-channel "still pending" flags while in StWrAw.
  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid || wready;

  // Loads format from the latched offset/op; stores format the live request at
  // acceptance so wdata/wstrb can be registered straight onto the bus.
  ysyx_lsu_fmt #(
    .BIT_W(BIT_W)
  ) u_fmt (
    .ld_op     (op_q),
    .ld_addr_lo(addr_lo_q),
    .rdata     (rdata),
    .ld_data   (ld_data),
    .st_size   (exu_op[1:0]),
    .st_addr_lo(exu_addr[1:0]),
    .st_data   (exu_wdata),
    .st_wdata  (st_wdata),
    .st_wstrb  (st_wstrb)
  );

  // Done pulses are set on the transition into StDone, so they are high for
  // exactly the one StDone cycle and cleared by the default below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_lo_q  <= '0;
      op_q       <= '0;
      exu_rdata  <= '0;
      exu_rvalid <= 1'b0;
      exu_wready <= 1'b0;
      exu_err    <= 1'b0;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      exu_rvalid <= 1'b0;
      exu_wready <= 1'b0;
      exu_err    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (exu_avalid && (exu_ren || exu_wen)) begin
            addr_lo_q <= exu_addr[1:0];
            op_q      <= exu_op[2:0];
            if (req_misaligned) begin
              exu_rvalid <= exu_ren;
              exu_wready <= !exu_ren;
              exu_err    <= 1'b1;
              state_q    <= StDone;
            end else if (exu_ren) begin
              araddr  <= exu_addr;
              arvalid <= 1'b1;
              state_q <= StRdA;
            end else begin
              awaddr  <= exu_addr;
              wdata   <= st_wdata;
              wstrb   <= st_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state_q <= StWrAw;
            end
          end
        end
        StRdA: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_q <= StRdD;
          end
        end
        StRdD: begin
          if (rvalid) begin
            rready     <= 1'b0;
            exu_rdata  <= ld_data;
            exu_rvalid <= 1'b1;
            exu_err    <= (rresp != RESP_OK);
            state_q    <= StDone;
          end
        end
        StWrAw: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready) wvalid <= 1'b0;
          if (aw_done && w_done) begin
            bready  <= 1'b1;
            state_q <= StWrB;
          end
        end
        StWrB: begin
          if (bvalid) begin
            bready     <= 1'b0;
            exu_wready <= 1'b1;
            exu_err    <= (bresp != RESP_OK);
            state_q    <= StDone;
          end
        end
        // The requester still holds exu_avalid here; it is deliberately not
        // sampled so the finished request is not taken a second time.
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
